// File: rtl/serial_add_unit.sv
// serial_add_unit: multi-cycle adder/subtracter that reuses one DIGIT-bit
// adder slice over WIDTH/DIGIT clock cycles, LSB-first.
// Operands are captured on START. The result F and the CO/OV/Z flags are
// loaded together at completion, which is marked by a one-cycle DONE pulse.
module serial_add_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] F,
  output logic             CO,
  output logic             OV,
  output logic             Z
);

  localparam int N = WIDTH / DIGIT;
  // The counter keeps at least one bit so that the N == 1 case stays legal.
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] f_reg;
  logic             co_reg;
  logic             ov_reg;
  logic             z_reg;

  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] res_next;
  logic             ov_next;

  // The shared adder slice: low digit of each operand plus the running carry.
  assign digit_sum = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_reg};

  // Each sum digit enters the result register from the top. After N steps,
  // the first digit has reached the bottom.
  assign res_next = (res_reg >> DIGIT)
                  | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  // On the last step, bit DIGIT-1 of the slice is the word MSB. If the sign
  // bits of the two addends agree but the sign bit of the sum differs, then
  // the carry into the MSB differs from the carry out of it.
  assign ov_next = (a_reg[DIGIT-1] == b_reg[DIGIT-1])
                && (digit_sum[DIGIT-1] != a_reg[DIGIT-1]);

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      f_reg     <= '0;
      co_reg    <= 1'b0;
      ov_reg    <= 1'b0;
      z_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        // FIN accepts a new START exactly as IDLE does, which allows
        // back-to-back operations.
        IDLE, FIN: begin
          if (START) begin
            a_reg     <= A;
            b_reg     <= SUB ? ~B : B;
            carry_reg <= SUB;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> DIGIT;
          b_reg     <= b_reg >> DIGIT;
          res_reg   <= res_next;
          carry_reg <= digit_sum[DIGIT];
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) begin
            f_reg     <= res_next;
            co_reg    <= digit_sum[DIGIT];
            ov_reg    <= ov_next;
            z_reg     <= (res_next == '0);
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= FIN;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign BUSY = busy_reg;
  assign DONE = done_reg;
  assign F    = f_reg;
  assign CO   = co_reg;
  assign OV   = ov_reg;
  assign Z    = z_reg;

endmodule

// File: tb/tb_serial_add_unit.sv
// tb_serial_add_unit: randomized scoreboard bench for three configurations:
// 8-bit/1-bit digits, 8-bit/4-bit digits and 16-bit/16-bit digits.
// The stimulus process pushes the expected result and completion cycle.
// The monitor checks BUSY, DONE and the held result on every cycle.
module tb_serial_add_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        st0, st1, st2;
  logic        sub_in;
  logic [15:0] a_in, b_in;

  logic        busy0, done0, co0, ov0, z0;
  logic [7:0]  f0;
  logic        busy1, done1, co1, ov1, z1;
  logic [7:0]  f1;
  logic        busy2, done2, co2, ov2, z2;
  logic [15:0] f2;

  always #5 CLK = ~CLK;

  serial_add_unit #(.WIDTH(8), .DIGIT(1)) u0 (
    .CLK(CLK), .RST(RST), .START(st0), .SUB(sub_in), .A(a_in[7:0]), .B(b_in[7:0]),
    .BUSY(busy0), .DONE(done0), .F(f0), .CO(co0), .OV(ov0), .Z(z0));

  serial_add_unit #(.WIDTH(8), .DIGIT(4)) u1 (
    .CLK(CLK), .RST(RST), .START(st1), .SUB(sub_in), .A(a_in[7:0]), .B(b_in[7:0]),
    .BUSY(busy1), .DONE(done1), .F(f1), .CO(co1), .OV(ov1), .Z(z1));

  serial_add_unit #(.WIDTH(16), .DIGIT(16)) u2 (
    .CLK(CLK), .RST(RST), .START(st2), .SUB(sub_in), .A(a_in), .B(b_in),
    .BUSY(busy2), .DONE(done2), .F(f2), .CO(co2), .OV(ov2), .Z(z2));

  typedef struct {
    int          id;
    int          n;
    int          due;
    logic [15:0] f;
    logic        co;
    logic        ov;
    logic        z;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  logic [15:0] last_f [3];
  logic        last_co [3];
  logic        last_ov [3];
  logic        last_z [3];

  function automatic int steps(input int id);
    return (id == 0) ? 8 : (id == 1) ? 2 : 1;
  endfunction

  function automatic int width_of(input int id);
    return (id == 2) ? 16 : 8;
  endfunction

  // Reference model: plain unsigned and signed integer arithmetic.
  function automatic exp_t model(input int id, input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input int due);
    exp_t   e;
    longint md, ua, ub, raw, sa, sbv, s;
    md  = longint'(1) << width_of(id);
    ua  = longint'(a) % md;
    ub  = longint'(b) % md;
    raw = sub ? ua - ub : ua + ub;
    e.f  = 16'((raw + md) % md);
    e.co = sub ? (ua >= ub) : (raw >= md);
    sa   = (ua >= md / 2) ? ua - md : ua;
    sbv  = (ub >= md / 2) ? ub - md : ub;
    s    = sub ? sa - sbv : sa + sbv;
    e.ov = (s >= md / 2) || (s < -(md / 2));
    e.z  = (e.f == 16'd0);
    e.id = id;
    e.n  = steps(id);
    e.due = due;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic busy, input logic done,
                            input logic [15:0] f, input logic co, input logic ov,
                            input logic z);
    logic  exp_busy, exp_done;
    string tag;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    if (sb.size() > 0 && sb[0].id == i) begin
      if (cyc >= sb[0].due - sb[0].n && cyc < sb[0].due) exp_busy = 1'b1;
      if (cyc == sb[0].due) exp_done = 1'b1;
    end
    tag = $sformatf("u%0d@cyc%0d", i, cyc);
    chk({tag, " busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, " done"}, 32'(done), 32'(exp_done));
    if (exp_done) begin
      last_f[i]  = sb[0].f;
      last_co[i] = sb[0].co;
      last_ov[i] = sb[0].ov;
      last_z[i]  = sb[0].z;
      sb.pop_front();
    end
    chk({tag, " F"},  32'(f),  32'(last_f[i]));
    chk({tag, " CO"}, 32'(co), 32'(last_co[i]));
    chk({tag, " OV"}, 32'(ov), 32'(last_ov[i]));
    chk({tag, " Z"},  32'(z),  32'(last_z[i]));
  endtask

  // Monitor: count rising edges and check every instance just after each edge.
  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      check_inst(0, busy0, done0, {8'h00, f0}, co0, ov0, z0);
      check_inst(1, busy1, done1, {8'h00, f1}, co1, ov1, z1);
      check_inst(2, busy2, done2, f2, co2, ov2, z2);
    end
  end

  task automatic set_start(input int id, input logic v);
    case (id)
      0:       st0 = v;
      1:       st1 = v;
      default: st2 = v;
    endcase
  endtask

  // Called at a falling edge. START is sampled at the next rising edge (cyc+1).
  task automatic launch(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic sub);
    a_in   = a;
    b_in   = b;
    sub_in = sub;
    set_start(id, 1'b1);
    sb.push_back(model(id, a, b, sub, cyc + 1 + steps(id)));
    $display("op u%0d: a=%0h b=%0h sub=%0b start_edge=%0d", id, a, b, sub, cyc + 1);
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 50 && sb.size() > 0; t++) @(negedge CLK);
    if (sb.size() > 0) begin
      chk("done timeout (pending ops)", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic sub);
    @(negedge CLK);
    launch(id, a, b, sub);
    @(negedge CLK);
    set_start(id, 1'b0);
    wait_empty();
  endtask

  // Scramble the operands on every RUN cycle.
  // With hold=1, START stays high until FIN, where the second operation launches.
  task automatic run_scramble(input int id, input logic [15:0] a, input logic [15:0] b,
                              input logic sub, input logic hold,
                              input logic [15:0] a2, input logic [15:0] b2, input logic sub2);
    int d;
    @(negedge CLK);
    launch(id, a, b, sub);
    d = cyc + 1 + steps(id);
    for (int t = 0; t < 40; t++) begin
      @(negedge CLK);
      if (cyc == d) begin
        if (hold) launch(id, a2, b2, sub2);
        else set_start(id, 1'b0);
        break;
      end
      a_in   = 16'($urandom);
      b_in   = 16'($urandom);
      sub_in = 1'($urandom_range(0, 1));
      set_start(id, hold);
    end
    if (hold) begin
      @(negedge CLK);
      set_start(id, 1'b0);
    end
    wait_empty();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      last_f[i] = '0; last_co[i] = 1'b0; last_ov[i] = 1'b0; last_z[i] = 1'b0;
    end
    // Hold START high during reset. Reset must win and start no operation.
    RST = 1'b1; st0 = 1'b1; st1 = 1'b0; st2 = 1'b0;
    sub_in = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0; st0 = 1'b0;

    run_op(0, 16'h007F, 16'h0001, 1'b0);
    run_op(0, 16'h00FF, 16'h0001, 1'b0);
    run_op(0, 16'h0005, 16'h0007, 1'b1);
    run_scramble(0, 16'h0080, 16'h0001, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    run_scramble(0, 16'h0080, 16'h0001, 1'b1, 1'b1, 16'h0012, 16'h0034, 1'b0);

    // Pulse START during RUN. The DUT must ignore it and give exactly one DONE.
    @(negedge CLK);
    launch(0, 16'h0033, 16'h0044, 1'b0);
    @(negedge CLK); st0 = 1'b0;
    @(negedge CLK);
    @(negedge CLK); st0 = 1'b1;
    @(negedge CLK); st0 = 1'b0;
    wait_empty();

    // Reset during step 3 of 8 (held from a rising edge + 2 to the falling edge).
    run_op(0, 16'h0080, 16'h0001, 1'b1);
    @(negedge CLK);
    launch(0, 16'h003C, 16'h0055, 1'b0);
    @(negedge CLK); st0 = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b1;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      last_f[i] = '0; last_co[i] = 1'b0; last_ov[i] = 1'b0; last_z[i] = 1'b0;
    end
    #1;
    chk("async rst busy", 32'(busy0), 32'd0);
    chk("async rst done", 32'(done0), 32'd0);
    chk("async rst F",    32'(f0),    32'd0);
    chk("async rst CO",   32'(co0),   32'd0);
    chk("async rst OV",   32'(ov0),   32'd0);
    chk("async rst Z",    32'(z0),    32'd0);
    #2;
    RST = 1'b0;
    run_op(0, 16'h0010, 16'h0020, 1'b0);

    run_op(1, 16'h009C, 16'h0064, 1'b0);
    run_op(2, 16'h8000, 16'h0001, 1'b1);

    for (int i = 0; i < 60; i++) begin
      run_scramble(i % 3, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
